// File: rtl/a2d_load_intf_if.sv
// -----------------------------------------------------------------------------
// a2d_load_intf_if
// Bundles the request/status/result signals and the SPI pins of the round-robin
// A/D load interface.
//   master : the converter block itself (drives SPI pins, results, status)
//   slave  : the environment (issues nxt, drives MISO from the A/D chip)
// Signals:
//   nxt        1  request to start the next conversion
//   MISO       1  serial data from the A/D
//   SS_n       1  A/D slave select, active low
//   SCLK       1  serial clock, idles high
//   MOSI       1  serial data to the A/D
//   lft_load  12  latest channel-0 result
//   rght_load 12  latest channel-4 result
//   steer_pot 12  latest channel-5 result
//   batt      12  latest channel-6 result
//   busy       1  conversion in progress
//   cnv_cmplt  1  one-clock pulse when a result register updates
// -----------------------------------------------------------------------------
interface a2d_load_intf_if;
   logic        nxt;
   logic        MISO;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic [11:0] lft_load;
   logic [11:0] rght_load;
   logic [11:0] steer_pot;
   logic [11:0] batt;
   logic        busy;
   logic        cnv_cmplt;

   modport master (
      input  nxt, MISO,
      output SS_n, SCLK, MOSI,
      output lft_load, rght_load, steer_pot, batt,
      output busy, cnv_cmplt
   );

   modport slave (
      output nxt, MISO,
      input  SS_n, SCLK, MOSI,
      input  lft_load, rght_load, steer_pot, batt,
      input  busy, cnv_cmplt
   );
endinterface

// File: rtl/a2d_load_intf.sv
// -----------------------------------------------------------------------------
// a2d_load_intf
// Round-robin SPI front end for the 8-channel 12-bit A/D converter. Each nxt
// request converts the next channel of the rotation 0 -> 4 -> 5 -> 6 -> 0 using
// a command transaction followed by a read transaction, and stores the 12-bit
// result in that channel's register.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  a2d_load_intf_if.master (nxt, MISO in; SS_n, SCLK, MOSI, results,
//        busy, cnv_cmplt out)
// Parameter:
//   SCLK_DIV  clk cycles per SCLK period (even, >= 4)
// -----------------------------------------------------------------------------
module a2d_load_intf #(
   parameter int SCLK_DIV = 32
) (
   input logic              clk,
   input logic              rst,
   a2d_load_intf_if.master  bus
);

   localparam int              DW        = $clog2(SCLK_DIV) + 1;
   localparam logic [DW-1:0]   HALF_LAST = DW'(SCLK_DIV / 2 - 1);
   localparam logic [DW-1:0]   FULL_LAST = DW'(SCLK_DIV - 1);
   localparam logic [4:0]      NUM_BITS  = 5'd16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      GAP  = 2'd2,
      READ = 2'd3
   } state_t;

   state_t          state_q,   state_d;
   logic [1:0]      ptr_q,     ptr_d;
   logic [DW-1:0]   div_cnt_q, div_cnt_d;
   logic [4:0]      bit_cnt_q, bit_cnt_d;
   logic [15:0]     shift_q,   shift_d;
   logic            ss_n_q,    ss_n_d;
   logic            sclk_q,    sclk_d;
   logic            mosi_q,    mosi_d;
   logic            busy_q,    busy_d;
   logic            cmplt_q,   cmplt_d;
   logic [11:0]     res_q [4];
   logic [15:0]     cmd_word;

   // Rotation slot -> physical A/D channel.
   function automatic logic [2:0] ptr_to_chnnl(input logic [1:0] p);
      case (p)
         2'd0:    return 3'd0;
         2'd1:    return 3'd4;
         2'd2:    return 3'd5;
         default: return 3'd6;
      endcase
   endfunction

   assign cmd_word = {2'b00, ptr_to_chnnl(ptr_q), 11'h000};

   // Within a transaction the elapsed time since SS_n fell is
   // bit_cnt*SCLK_DIV + div_cnt: SCLK falls at mid-period, rises at period end.
   // MISO is captured into the LSB as SCLK rises (the shift happens on that
   // same clock), and MOSI is a separate flop reloaded from the shift MSB only
   // at SCLK falls, so MOSI never moves around a rising edge.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      div_cnt_d = div_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      ss_n_d    = ss_n_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      busy_d    = busy_q;
      cmplt_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.nxt) begin
               state_d   = CMD;
               busy_d    = 1'b1;
               ss_n_d    = 1'b0;
               sclk_d    = 1'b1;
               shift_d   = cmd_word;
               mosi_d    = cmd_word[15];
               div_cnt_d = '0;
               bit_cnt_d = '0;
            end
         end

         GAP: begin
            div_cnt_d = div_cnt_q + 1'b1;
            if (div_cnt_q == FULL_LAST) begin
               state_d   = READ;
               ss_n_d    = 1'b0;
               shift_d   = 16'h0000;
               mosi_d    = 1'b0;
               div_cnt_d = '0;
               bit_cnt_d = '0;
            end
         end

         CMD, READ: begin
            div_cnt_d = div_cnt_q + 1'b1;
            if (bit_cnt_q == NUM_BITS) begin
               // Back porch: half a period with SCLK high before SS_n rises.
               if (div_cnt_q == HALF_LAST) begin
                  ss_n_d    = 1'b1;
                  mosi_d    = 1'b0;
                  div_cnt_d = '0;
                  bit_cnt_d = '0;
                  if (state_q == CMD) begin
                     state_d = GAP;
                  end else begin
                     state_d = IDLE;
                     busy_d  = 1'b0;
                     cmplt_d = 1'b1;
                     ptr_d   = ptr_q + 1'b1;
                  end
               end
            end else if (div_cnt_q == HALF_LAST) begin
               sclk_d = 1'b0;
               mosi_d = shift_q[15];
            end else if (div_cnt_q == FULL_LAST) begin
               sclk_d    = 1'b1;
               div_cnt_d = '0;
               bit_cnt_d = bit_cnt_q + 1'b1;
               shift_d   = {shift_q[14:0], bus.MISO};
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         div_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         ss_n_q    <= 1'b1;
         sclk_q    <= 1'b1;
         mosi_q    <= 1'b0;
         busy_q    <= 1'b0;
         cmplt_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         div_cnt_q <= div_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         ss_n_q    <= ss_n_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         busy_q    <= busy_d;
         cmplt_q   <= cmplt_d;
      end
   end

   // The shift register already holds the full READ word when SS_n rises, so
   // the selected result register loads on the completing clock itself.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            res_q[i] <= '0;
         end
      end else if (cmplt_d) begin
         res_q[ptr_q] <= shift_q[11:0];
      end
   end

   assign bus.SS_n      = ss_n_q;
   assign bus.SCLK      = sclk_q;
   assign bus.MOSI      = mosi_q;
   assign bus.busy      = busy_q;
   assign bus.cnv_cmplt = cmplt_q;
   assign bus.lft_load  = res_q[0];
   assign bus.rght_load = res_q[1];
   assign bus.steer_pot = res_q[2];
   assign bus.batt      = res_q[3];

endmodule

// File: tb/tb_a2d_load_intf.sv
// -----------------------------------------------------------------------------
// tb_a2d_load_intf
// Scoreboard bench for a2d_load_intf: stimulus pushes expected MOSI words and
// expected results into queues; an A/D slave model and a completion monitor pop
// and compare; an SPI timing checker watches every edge.
// -----------------------------------------------------------------------------
module tb_a2d_load_intf;

   localparam int DIV  = 32;
   localparam int HALF = DIV / 2;
   // nxt -> cnv_cmplt: 1 + two transactions of 16.5 periods + one gap period.
   localparam int LAT  = 1 + 33 * DIV + DIV;

   logic clk = 1'b0;
   logic rst = 1'b1;

   a2d_load_intf_if bus ();

   a2d_load_intf #(.SCLK_DIV(DIV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int idx;
      int val;
      int due;
   } exp_t;

   logic [15:0] resp [8];     // what the A/D returns for each channel
   exp_t        exp_res[$];
   int          exp_mosi[$];
   int          model_ptr  = 0;
   int          model_free = 0;   // first issue cycle at which nxt is accepted
   int          done_cnt   = 0;
   int          res_model [4];

   function automatic int ch_of(input int p);
      case (p)
         0:       return 0;
         1:       return 4;
         2:       return 5;
         default: return 6;
      endcase
   endfunction

   function automatic int out_val(input int i);
      case (i)
         0:       return int'(bus.lft_load);
         1:       return int'(bus.rght_load);
         2:       return int'(bus.steer_pot);
         default: return int'(bus.batt);
      endcase
   endfunction

   // ---------------- A/D slave model ----------------
   logic        prev_ss   = 1'b1;
   logic        prev_sclk = 1'b1;
   bit          in_xfer   = 1'b0;
   int          nrise     = 0;
   int          last_ch   = 0;
   logic [15:0] rx_sh     = '0;
   logic [15:0] miso_sh   = '0;

   always @(bus.SS_n or bus.SCLK) begin
      if (prev_ss && !bus.SS_n) begin
         in_xfer  = 1'b1;
         nrise    = 0;
         rx_sh    = '0;
         miso_sh  = resp[last_ch];
         bus.MISO = miso_sh[15];
      end else if (!prev_ss && bus.SS_n) begin
         if (in_xfer && !rst) begin
            chk("spi_rise_count", nrise, 16);
            if (exp_mosi.size() == 0) begin
               total++;
               bad++;
               $display("FAIL mosi_word: got 0x%0h with no transaction expected (cycle %0d)", rx_sh, cyc);
            end else begin
               chk("mosi_word", int'(rx_sh), exp_mosi.pop_front());
            end
            last_ch = int'(rx_sh[13:11]);
         end
         in_xfer = 1'b0;
      end else if (in_xfer && !bus.SS_n) begin
         if (prev_sclk && !bus.SCLK) begin
            if (nrise > 0) miso_sh = miso_sh << 1;
            bus.MISO = miso_sh[15];
         end else if (!prev_sclk && bus.SCLK) begin
            rx_sh = {rx_sh[14:0], bus.MOSI};
            nrise++;
         end
      end
      prev_ss   = bus.SS_n;
      prev_sclk = bus.SCLK;
   end

   // ---------------- completion monitor ----------------
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst) begin
         for (int i = 0; i < 4; i++) res_model[i] = 0;
      end else if (bus.cnv_cmplt) begin
         if (exp_res.size() == 0) begin
            total++;
            bad++;
            $display("FAIL cnv_cmplt: got pulse, expected none (cycle %0d)", cyc);
         end else begin
            e = exp_res.pop_front();
            chk("cnv_latency_cycle", cyc, e.due);
            res_model[e.idx] = e.val;
            for (int i = 0; i < 4; i++)
               chk($sformatf("result_reg%0d", i), out_val(i), res_model[i]);
            chk("busy_at_cmplt", bus.busy, 0);
            done_cnt++;
         end
      end
   end

   // ---------------- SPI timing checker ----------------
   logic c_sclk = 1'b1, c_ss = 1'b1, c_mosi = 1'b0;
   int   since = 0;
   int   sclk_edges = 0;
   bit   gap_pend = 1'b0, phase = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         c_sclk   = 1'b1;
         c_ss     = 1'b1;
         c_mosi   = 1'b0;
         since    = 0;
         gap_pend = 1'b0;
         phase    = 1'b0;
      end else begin
         since++;
         if (c_sclk != bus.SCLK) sclk_edges++;
         if (!c_sclk && bus.SCLK) chk("mosi_stable_at_rise", bus.MOSI, c_mosi);
         if ((c_sclk != bus.SCLK) || (!c_ss && bus.SS_n)) begin
            chk("sclk_half_width", since, HALF);
            since = 0;
         end
         if (c_ss && !bus.SS_n) begin
            if (gap_pend) chk("ss_gap_width", since, DIV);
            gap_pend = 1'b0;
            since    = 0;
         end
         if (!c_ss && bus.SS_n) begin
            gap_pend = (phase == 1'b0);
            phase    = ~phase;
         end
         c_sclk = bus.SCLK;
         c_ss   = bus.SS_n;
         c_mosi = bus.MOSI;
      end
   end

   // ---------------- stimulus ----------------
   // All tasks start and end 1 time unit after a rising clock edge.
   task automatic issue_nxt();
      bit   acc;
      int   ch;
      exp_t e;
      acc = (cyc >= model_free);
      bus.nxt = 1'b1;
      if (acc) begin
         ch = ch_of(model_ptr);
         exp_mosi.push_back(ch << 11);
         exp_mosi.push_back(0);
         e.idx = model_ptr;
         e.val = int'(resp[ch][11:0]);
         e.due = cyc + LAT;
         exp_res.push_back(e);
         model_ptr  = (model_ptr + 1) % 4;
         model_free = cyc + LAT;
      end
      @(posedge clk);
      #1;
      bus.nxt = 1'b0;
      if (acc) begin
         chk("ss_n_cycle0", bus.SS_n, 0);
         chk("busy_cycle0", bus.busy, 1);
      end
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while (exp_res.size() != 0 && n < LAT + 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("conv_done_in_time", exp_res.size(), 0);
      if (exp_res.size() != 0) begin
         exp_res.delete();
         exp_mosi.delete();
         model_free = 0;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_SS_n"}, bus.SS_n, 1);
      chk({tag, "_SCLK"}, bus.SCLK, 1);
      chk({tag, "_MOSI"}, bus.MOSI, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_cnv_cmplt"}, bus.cnv_cmplt, 0);
      for (int i = 0; i < 4; i++) chk($sformatf("%s_result%0d", tag, i), out_val(i), 0);
   endtask

   task automatic clear_model();
      exp_res.delete();
      exp_mosi.delete();
      model_ptr  = 0;
      model_free = 0;
   endtask

   initial begin
      int c0, d0, e0, g;
      bus.nxt = 1'b0;
      for (int i = 0; i < 8; i++) resp[i] = 16'(i * 16'h1111);
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;

      // Idle after reset: reset values, no SCLK activity.
      e0 = sclk_edges;
      repeat (100) @(posedge clk);
      #1;
      check_reset_outputs("idle");
      chk("idle_sclk_edges", sclk_edges - e0, 0);
      $display("idle check done at cycle %0d", cyc);

      // Single conversion of channel 0.
      resp[0] = 16'h02A5;
      issue_nxt();
      wait_done();
      chk("lft_load_02A5", bus.lft_load, 12'h2A5);
      chk("rght_load_held", bus.rght_load, 0);
      chk("steer_pot_held", bus.steer_pot, 0);
      chk("batt_held", bus.batt, 0);
      $display("single conversion: lft_load=%h", bus.lft_load);

      // Realign rotation, then five back-to-back conversions.
      @(posedge clk);
      #2 rst = 1'b1;
      clear_model();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      resp[0] = 16'h0ABC;
      resp[4] = 16'hF123;
      resp[5] = 16'h0456;
      resp[6] = 16'h5789;
      for (int k = 0; k < 5; k++) begin
         issue_nxt();
         wait_done();
         $display("conversion %0d: lft=%h rght=%h steer=%h batt=%h", k,
                  bus.lft_load, bus.rght_load, bus.steer_pot, bus.batt);
      end
      chk("rght_load_F123", bus.rght_load, 12'h123);

      // Requests while busy (cycle 10, 500, completion clock) are ignored.
      c0 = cyc;
      d0 = done_cnt;
      issue_nxt();
      wait_until(c0 + 10);
      issue_nxt();
      wait_until(c0 + 500);
      issue_nxt();
      wait_until(c0 + LAT - 1);
      issue_nxt();
      issue_nxt();
      wait_done();
      chk("conversions_with_ignored_nxt", done_cnt - d0, 2);
      $display("ignored-nxt sequence: %0d conversions", done_cnt - d0);

      // Reset 200 clocks into the READ transaction.
      c0 = cyc;
      issue_nxt();
      wait_until(c0 + 1 + 16 * DIV + HALF + DIV + 200);
      chk("busy_before_reset", bus.busy, 1);
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("midread_rst");
      clear_model();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      resp[0] = 16'h7E01;
      issue_nxt();
      wait_done();
      chk("post_reset_lft_load", bus.lft_load, 12'hE01);
      $display("after mid-read reset: lft_load=%h", bus.lft_load);

      // Randomized conversions with a stray nxt during each one.
      for (int k = 0; k < 6; k++) begin
         repeat ($urandom_range(0, 20)) @(posedge clk);
         #1;
         resp[ch_of(model_ptr)] = 16'($urandom);
         c0 = cyc;
         issue_nxt();
         g = $urandom_range(2, LAT - 2);
         wait_until(c0 + g);
         issue_nxt();
         wait_done();
         $display("random conversion %0d: lft=%h rght=%h steer=%h batt=%h", k,
                  bus.lft_load, bus.rght_load, bus.steer_pot, bus.batt);
      end

      repeat (50) @(posedge clk);
      #1;
      chk("mosi_queue_empty", exp_mosi.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: got no completion, expected finish before time limit");
      $fatal(1, "timeout");
   end

endmodule
